stage_x: RTL
============

// Module: stage_x
// PURPOSE
//  Execute stage of the 64-bit Polaris integer pipeline, directly upstream of stage_m.
//  Computes the ALU result (either the effective address or the arithmetic result).
//  Forwards the M-stage result to resolve RAW hazards.
//  Registers everything stage_m consumes: cycle size, address/result, store data, destination, signedness, store flag.
//  Holds its output registers while stage_m stalls.
// PARAMETERS
//  (none)  Fixed 64-bit datapath, 32 registers; x0 reads as zero.
// PORTS
//  clk_i            in   1   Clock; all state updates on the rising edge.
//  reset_i          in   1   Synchronous, active-high reset.
//  x_op_i           in   4   ALU op: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND; 10-15 give result 0.
//  x_word_i         in   1   32-bit (W) op: sign-extend result bit 31 to 63:32.
//  x_rs1_i          in   5   Operand A register specifier.
//  x_rs2_i          in   5   Operand B / store-data register specifier.
//  x_rs1_dat_i      in   64  Register file value for rs1.
//  x_rs2_dat_i      in   64  Register file value for rs2.
//  x_imm_i          in   64  Sign-extended immediate.
//  x_bsel_i         in   1   Operand B select: 0 = forwarded rs2, 1 = x_imm_i.
//  x_cyc_i          in   4   Memory cycle size: 0 (none), 1, 2, 4 or 8 bytes.
//  x_store_i        in   1   Instruction is a store.
//  x_unsigned_i     in   1   Load is zero-extending.
//  x_destination_i  in   5   Writeback register; 0 = no writeback.
//  m_result_i       in   64  Result from stage_m (forwarding source).
//  m_destination_i  in   5   Destination from stage_m (forwarding tag).
//  m_stall_i        in   1   stage_m stall request.
//  x_stall_o        out  1   Stall to decode/fetch; equals m_stall_i (combinational).
//  m_cyc_o          out  4   Registered x_cyc_i.
//  m_alu_o          out  64  Registered ALU result.
//  m_wrdata_o       out  64  Registered forwarded rs2 value (store data).
//  m_store_o        out  1   Registered x_store_i.
//  m_unsigned_o     out  1   Registered x_unsigned_i.
//  m_destination_o  out  5   Registered x_destination_i.
// BEHAVIOUR
//  Reset:
//   - reset_i=1 at an edge clears all m_* outputs to 0, giving a bubble.
//   - Reset takes priority over m_stall_i.
//  Forwarding (combinational):
//   - opA = m_result_i when x_rs1_i == m_destination_i and x_rs1_i != 0; otherwise x_rs1_dat_i.
//   - rs2 forwarding uses the same rule.
//   - x0 is never forwarded.
//  Operands: opB = x_bsel_i ? x_imm_i : forwarded rs2.
//  Store data: m_wrdata_o always captures forwarded rs2, regardless of x_bsel_i.
//  Shift amount:
//   - opB[5:0] for 64-bit ops.
//   - opB[4:0] for W ops.
//  W shifts:
//   - SLL shifts opA[31:0].
//   - SRL shifts {32'b0, opA[31:0]}.
//   - SRA shifts opA[31:0] with bit 31 as the fill.
//   - The result is then sign-extended from bit 31.
//  W arithmetic: ADD/SUB take the 64-bit result, then sign-extend bits 31:0.
//  Compares: SLT is signed, SLTU is unsigned; result is 0 or 1 in bit 0, zero-extended.
//  Arithmetic wraps modulo 2^64; no overflow flag.
//  Latency: one cycle. Inputs presented before edge N appear on m_* after edge N.
//  Stall:
//   - m_stall_i=1 at an edge holds every m_* register unchanged.
//   - Upstream must hold x_* inputs while x_stall_o=1.
//   - Forwarding stays live during a stall.
//  Simultaneous events: reset > stall > load.
// TESTING
//  1. reset_i=1, x_cyc_i=8, x_store_i=1 -> after edge: m_cyc_o=0, m_store_o=0, m_alu_o=0, m_destination_o=0.
//  2. ADD rs1=0x1122334455667788, imm=0x10, bsel=1, cyc=0, dest=4 -> m_alu_o=0x1122334455667798, m_destination_o=4.
//  3. ADDW rs1=0x7FFFFFFF, imm=1 -> m_alu_o=0xFFFFFFFF80000000.
//     SRAW rs1=0x80000000, imm=4 -> m_alu_o=0xFFFFFFFFF8000000.
//  4. SLT(-1,1) -> 1; SLTU(-1,1) -> 0.
//     SRA 0x8000000000000000 by 63 -> 0xFFFFFFFFFFFFFFFF.
//  5. Forwarding: m_destination_i=14, m_result_i=0xAA, x_rs1_i=14 -> m_alu_o uses 0xAA.
//     With x_rs1_i=0 and m_destination_i=0 -> rs1 register value is used.
//  6. Stall:
//     - m_stall_i=1 for 3 edges with new inputs (dest=31) -> outputs hold (dest=14); x_stall_o=1.
//     - Deassert -> new values appear after the next edge.
//     - reset_i=1 during the stall -> outputs cleared.

Source files
------------

// File: rtl/stage_x_if.sv
// Bundle of the execute-stage signals shared by decode (x_*), stage_m (m_*) and stage_x.
// The master drives instructions and forwarding; the slave is stage_x.
interface stage_x_if;
  logic [3:0]  x_op_i;
  logic        x_word_i;
  logic [4:0]  x_rs1_i;
  logic [4:0]  x_rs2_i;
  logic [63:0] x_rs1_dat_i;
  logic [63:0] x_rs2_dat_i;
  logic [63:0] x_imm_i;
  logic        x_bsel_i;
  logic [3:0]  x_cyc_i;
  logic        x_store_i;
  logic        x_unsigned_i;
  logic [4:0]  x_destination_i;
  logic [63:0] m_result_i;
  logic [4:0]  m_destination_i;
  logic        m_stall_i;
  logic        x_stall_o;
  logic [3:0]  m_cyc_o;
  logic [63:0] m_alu_o;
  logic [63:0] m_wrdata_o;
  logic        m_store_o;
  logic        m_unsigned_o;
  logic [4:0]  m_destination_o;

  modport master (
    output x_op_i, x_word_i, x_rs1_i, x_rs2_i, x_rs1_dat_i, x_rs2_dat_i, x_imm_i,
           x_bsel_i, x_cyc_i, x_store_i, x_unsigned_i, x_destination_i,
           m_result_i, m_destination_i, m_stall_i,
    input  x_stall_o, m_cyc_o, m_alu_o, m_wrdata_o, m_store_o, m_unsigned_o,
           m_destination_o
  );

  modport slave (
    input  x_op_i, x_word_i, x_rs1_i, x_rs2_i, x_rs1_dat_i, x_rs2_dat_i, x_imm_i,
           x_bsel_i, x_cyc_i, x_store_i, x_unsigned_i, x_destination_i,
           m_result_i, m_destination_i, m_stall_i,
    output x_stall_o, m_cyc_o, m_alu_o, m_wrdata_o, m_store_o, m_unsigned_o,
           m_destination_o
  );
endinterface

// File: rtl/stage_x.sv
// Execute stage of the 64-bit Polaris pipeline: operand forwarding from stage_m,
// ALU (64-bit and W forms), and the X->M pipeline register with stall hold.
module stage_x (
  input logic       clk_i,
  input logic       reset_i,
  stage_x_if.slave  bus
);

  logic [63:0] w_opa;
  logic [63:0] w_rs2;
  logic [63:0] w_opb;
  logic [5:0]  w_shamt;
  logic [63:0] w_sll_src;
  logic [63:0] w_srl_src;
  logic [63:0] w_sra_src;
  logic [63:0] w_raw;
  logic [63:0] w_alu;

  logic [3:0]  r_cyc;
  logic [63:0] r_alu;
  logic [63:0] r_wrdata;
  logic        r_store;
  logic        r_unsigned;
  logic [4:0]  r_dest;

  // x0 is never a forwarding match, even if stage_m reports destination 0.
  assign w_opa = (bus.x_rs1_i != 5'd0 && bus.x_rs1_i == bus.m_destination_i)
                 ? bus.m_result_i : bus.x_rs1_dat_i;
  assign w_rs2 = (bus.x_rs2_i != 5'd0 && bus.x_rs2_i == bus.m_destination_i)
                 ? bus.m_result_i : bus.x_rs2_dat_i;
  assign w_opb = bus.x_bsel_i ? bus.x_imm_i : w_rs2;

  assign w_shamt   = bus.x_word_i ? {1'b0, w_opb[4:0]} : w_opb[5:0];
  assign w_sll_src = bus.x_word_i ? {32'b0, w_opa[31:0]} : w_opa;
  assign w_srl_src = bus.x_word_i ? {32'b0, w_opa[31:0]} : w_opa;
  // W arithmetic shift fills from bit 31, so pre-extend before shifting.
  assign w_sra_src = bus.x_word_i ? {{32{w_opa[31]}}, w_opa[31:0]} : w_opa;

  always_comb begin
    w_raw = 64'd0;
    case (bus.x_op_i)
      4'd0: w_raw = w_opa + w_opb;
      4'd1: w_raw = w_opa - w_opb;
      4'd2: w_raw = w_sll_src << w_shamt;
      4'd3: w_raw = {63'd0, $signed(w_opa) < $signed(w_opb)};
      4'd4: w_raw = {63'd0, w_opa < w_opb};
      4'd5: w_raw = w_opa ^ w_opb;
      4'd6: w_raw = w_srl_src >> w_shamt;
      4'd7: w_raw = $unsigned($signed(w_sra_src) >>> w_shamt);
      4'd8: w_raw = w_opa | w_opb;
      4'd9: w_raw = w_opa & w_opb;
      default: w_raw = 64'd0;
    endcase
  end

  assign w_alu = bus.x_word_i ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;

  // Priority: reset, then stall hold, then load.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cyc      <= 4'd0;
      r_alu      <= 64'd0;
      r_wrdata   <= 64'd0;
      r_store    <= 1'b0;
      r_unsigned <= 1'b0;
      r_dest     <= 5'd0;
    end else if (!bus.m_stall_i) begin
      r_cyc      <= bus.x_cyc_i;
      r_alu      <= w_alu;
      r_wrdata   <= w_rs2;
      r_store    <= bus.x_store_i;
      r_unsigned <= bus.x_unsigned_i;
      r_dest     <= bus.x_destination_i;
    end
  end

  assign bus.x_stall_o       = bus.m_stall_i;
  assign bus.m_cyc_o         = r_cyc;
  assign bus.m_alu_o         = r_alu;
  assign bus.m_wrdata_o      = r_wrdata;
  assign bus.m_store_o       = r_store;
  assign bus.m_unsigned_o    = r_unsigned;
  assign bus.m_destination_o = r_dest;

endmodule
